spi_ram_master: RTL and testbench

SPI transaction sequencer that drives the single-clock SPI RAM slave (`spi_wrapper`) from a simple parallel request/response port. It converts one host request (byte write or byte read at an 8-bit address) into the required pair of 10-bit SPI frames, then returns read data or a write completion. It sits between on-chip control logic and the `MOSI`/`MISO`/`SS_n` pins of the RAM slave, and shares that slave's `clk`.

---
 rtl/spi_ram_master.sv | 204 ++++++++++++++++++++
 tb/tb_spi_ram_master.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_ram_master.sv
// spi_ram_master: turns one parallel byte read/write request into the pair of
// 10-bit SPI frames expected by the SPI RAM slave, then reports completion.
// Optional feature: define SPI_ADDR_CACHE_EN to skip address frames that
// repeat the last write/read address already sent to the slave.
module spi_ram_master #(
  parameter int unsigned TURNAROUND = 2,
  parameter int unsigned GAP        = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_wr,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  localparam int unsigned CW = 4;
  localparam int unsigned FW = 10;
  localparam logic [CW-1:0] SHIFT_LAST = CW'(FW - 1);
  localparam logic [CW-1:0] CAP_LAST   = CW'(7);
  localparam logic [CW-1:0] TURN_LAST  = CW'(TURNAROUND - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_SHIFT, S_TURN, S_CAPTURE, S_GAP, S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          second_q, second_d;
  logic          wr_q, wr_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          ss_n_q, ss_n_d;
  logic          mosi_q, mosi_d;
  logic          ready_q, ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [FW-1:0] frame;

`ifdef SPI_ADDR_CACHE_EN
  logic       wa_vld_q, wa_vld_d, ra_vld_q, ra_vld_d;
  logic [7:0] wa_q, wa_d, ra_q, ra_d;
`endif

  // Current frame: command {read, second}, payload is address or data
  assign frame = {~wr_q, second_q,
                  second_q ? (wr_q ? wdata_q : 8'h00) : addr_q};

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    second_d    = second_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    shift_d     = shift_q;
    rdata_d     = rdata_q;
`ifdef SPI_ADDR_CACHE_EN
    wa_vld_d    = wa_vld_q;
    ra_vld_d    = ra_vld_q;
    wa_d        = wa_q;
    ra_d        = ra_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (req_valid && ready_q) begin
          wr_d     = req_wr;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          second_d = 1'b0;
          cnt_d    = '0;
          state_d  = S_SETUP;
`ifdef SPI_ADDR_CACHE_EN
          if (req_wr) begin
            second_d = wa_vld_q && (wa_q == req_addr);
            wa_vld_d = 1'b1;
            wa_d     = req_addr;
          end else begin
            second_d = ra_vld_q && (ra_q == req_addr);
            ra_vld_d = 1'b1;
            ra_d     = req_addr;
          end
`endif
        end
      end
      S_SETUP: begin
        cnt_d   = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (cnt_q == SHIFT_LAST) begin
          cnt_d   = '0;
          state_d = (second_q && !wr_q) ? S_TURN : S_GAP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_TURN: begin
        if (cnt_q == TURN_LAST) begin
          cnt_d   = '0;
          state_d = S_CAPTURE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_CAPTURE: begin
        shift_d = {shift_q[6:0], MISO};
        if (cnt_q == CAP_LAST) begin
          cnt_d   = '0;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (second_q) begin
            state_d = S_DONE;
            if (!wr_q) rdata_d = shift_q;
          end else begin
            state_d  = S_SETUP;
            second_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    ss_n_d      = !(state_d == S_SETUP || state_d == S_SHIFT ||
                    state_d == S_TURN  || state_d == S_CAPTURE);
    mosi_d      = (state_d == S_SHIFT) ? frame[SHIFT_LAST - cnt_d] : 1'b0;
    ready_d     = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_DONE);
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      second_q    <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= 8'h00;
      wdata_q     <= 8'h00;
      shift_q     <= 8'h00;
      rdata_q     <= 8'h00;
      ss_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      second_q    <= second_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      shift_q     <= shift_d;
      rdata_q     <= rdata_d;
      ss_n_q      <= ss_n_d;
      mosi_q      <= mosi_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

`ifdef SPI_ADDR_CACHE_EN
  // Last-sent address cache, cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wa_vld_q <= 1'b0;
      ra_vld_q <= 1'b0;
      wa_q     <= 8'h00;
      ra_q     <= 8'h00;
    end else begin
      wa_vld_q <= wa_vld_d;
      ra_vld_q <= ra_vld_d;
      wa_q     <= wa_d;
      ra_q     <= ra_d;
    end
  end
`endif

  assign SS_n      = ss_n_q;
  assign MOSI      = mosi_q;
  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_spi_ram_master.sv
// Bench for spi_ram_master: a frame-level SPI RAM slave plus a request-level
// memory/latency model; directed cases followed by randomized requests.
module tb_spi_ram_master;

  localparam int T = 2;
  localparam int G = 1;

  logic       clk, rst_n;
  logic       req_valid, req_ready, req_wr;
  logic [7:0] req_addr, req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       SS_n, MOSI, MISO;

  int errs   = 0;
  int checks = 0;
  int viol   = 0;
  int fr_rd  = 0;
  logic [9:0] frames[$];
  logic [7:0] ref_mem[256];
  logic [7:0] last_rdata;
  bit         cwv, crv;
  logic [7:0] cwa, cra;

  spi_ram_master #(.TURNAROUND(T), .GAP(G)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .SS_n      (SS_n),
    .MOSI      (MOSI),
    .MISO      (MISO)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] init_val(input int i);
    if (i == 255) return 8'h5A;
    if (i == 0)   return 8'hC3;
    return 8'((i * 29 + 7) & 255);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // SPI RAM slave: decodes complete frames, answers read-data frames on MISO
  initial begin : slave
    logic [7:0] smem[256];
    logic [9:0] sh;
    logic [7:0] wa, ra, rbyte;
    int         ss_cnt, k;
    bit         ract;
    for (int i = 0; i < 256; i++) smem[i] = init_val(i);
    ss_cnt = 0; ract = 0; wa = 0; ra = 0; rbyte = 0; sh = 0; MISO = 1'b0;
    forever begin
      @(negedge clk);
      if (SS_n) begin
        ss_cnt = 0;
        ract   = 0;
        MISO   = 1'b0;
        if (MOSI !== 1'b0) viol++;
      end else begin
        ss_cnt++;
        if (ss_cnt == 1) begin
          if (MOSI !== 1'b0) viol++;
        end else if (ss_cnt <= 11) begin
          sh = {sh[8:0], MOSI};
          if (ss_cnt == 11) begin
            frames.push_back(sh);
            case (sh[9:8])
              2'b00:   wa = sh[7:0];
              2'b01:   smem[wa] = sh[7:0];
              2'b10:   ra = sh[7:0];
              default: begin rbyte = smem[ra]; ract = 1; end
            endcase
          end
        end
        if (ract && ss_cnt >= 12 + T && ss_cnt < 20 + T) begin
          k = 19 + T - ss_cnt;
          MISO = rbyte[k];
        end else begin
          MISO = 1'b0;
        end
      end
    end
  end

  // One host request: expected frames, latency and read data from the model
  task automatic do_req(input logic wr, input logic [7:0] addr, input logic [7:0] wd);
    int         n, exp_lat;
    bit         hit, busy_ready;
    logic [9:0] exp_fr[$];
    hit = 0;
    busy_ready = 0;
`ifdef SPI_ADDR_CACHE_EN
    if (wr) begin hit = cwv && (cwa == addr); cwv = 1; cwa = addr; end
    else    begin hit = crv && (cra == addr); crv = 1; cra = addr; end
`endif
    if (wr) begin
      exp_lat = hit ? 12 + G : 2 * (11 + G) + 1;
      if (!hit) exp_fr.push_back({2'b00, addr});
      exp_fr.push_back({2'b01, wd});
      ref_mem[addr] = wd;
    end else begin
      exp_lat = hit ? 20 + T + G : (11 + G) + (11 + T + 8 + G) + 1;
      if (!hit) exp_fr.push_back({2'b10, addr});
      exp_fr.push_back({2'b11, 8'h00});
      last_rdata = ref_mem[addr];
    end

    @(negedge clk);
    chk("ready_idle", 32'(req_ready), 32'd1);
    chk("rsp_pulse_end", 32'(rsp_valid), 32'd0);
    req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'($urandom); req_wr = 1'($urandom);
    req_addr = 8'($urandom); req_wdata = 8'($urandom);
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (rsp_valid) break;
      if (req_ready) busy_ready = 1;
      req_valid = 1'($urandom); req_wr = 1'($urandom);
      req_addr = 8'($urandom); req_wdata = 8'($urandom);
    end
    req_valid = 1'b0;
    chk(wr ? "wr_latency" : "rd_latency", 32'(n), 32'(exp_lat));
    chk("rsp_rdata", 32'(rsp_rdata), 32'(last_rdata));
    chk("ready_low_busy", 32'(busy_ready), 32'd0);
    chk("frame_count", 32'(frames.size() - fr_rd), 32'(exp_fr.size()));
    for (int i = 0; i < exp_fr.size() && fr_rd + i < frames.size(); i++)
      chk("frame", 32'(frames[fr_rd + i]), 32'(exp_fr[i]));
    fr_rd = frames.size();
  endtask

  initial begin : main
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    last_rdata = 8'h00;
    cwv = 0; crv = 0; cwa = 0; cra = 0;

    // Reset with a request pending
    rst_n = 1'b0; req_valid = 1'b1; req_wr = 1'b1;
    req_addr = 8'h3C; req_wdata = 8'hA5;
    repeat (3) begin
      @(negedge clk);
      chk("rst_ss_n", 32'(SS_n), 32'd1);
      chk("rst_mosi", 32'(MOSI), 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rdata", 32'(rsp_rdata), 32'd0);
    end
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("idle_ss_n", 32'(SS_n), 32'd1);
    end

    // Directed write/read sequence
    do_req(1'b1, 8'h3C, 8'hA5);
    do_req(1'b0, 8'h3C, 8'h00);
    do_req(1'b0, 8'hFF, 8'h00);
    do_req(1'b0, 8'h00, 8'h00);

    // Reset during the write-data frame shift
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 8'h77; req_wdata = 8'h11;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (17) @(posedge clk);
    #1 chk("ss_low_before_rst", 32'(SS_n), 32'd0);
    #1 rst_n = 1'b0;
    #1 chk("ss_async_rst", 32'(SS_n), 32'd1);
    chk("mosi_async_rst", 32'(MOSI), 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("abort_ready", 32'(req_ready), 32'd1);
    end
    chk("abort_rdata", 32'(rsp_rdata), 32'd0);
    rst_n = 1'b1;
    cwv = 0; crv = 0; last_rdata = 8'h00;
    fr_rd = frames.size();
    @(negedge clk);
    chk("post_abort_rsp", 32'(rsp_valid), 32'd0);

    do_req(1'b1, 8'h3C, 8'h42);
    do_req(1'b0, 8'h3C, 8'h00);

    // Repeated address (skipped frame when the address cache is built in)
    do_req(1'b1, 8'h10, 8'h55);
    do_req(1'b1, 8'h10, 8'h66);
    do_req(1'b0, 8'h10, 8'h00);
    do_req(1'b0, 8'h10, 8'h00);

    // Randomized requests over a small address mix
    for (int i = 0; i < 30; i++) begin
      int         sel;
      logic [7:0] a;
      sel = int'($urandom_range(0, 3));
      a = (sel == 0) ? 8'h10 : (sel == 1) ? 8'h3C : 8'($urandom);
      do_req(1'($urandom), a, 8'($urandom));
    end

    chk("mosi_zero_outside_shift", 32'(viol), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
